clock_controller: RTL and testbench
===================================

Name: clock_controller

Overview:
- Front-panel sequencer for the system clock block. Debounces the raw run, step and burst buttons and latches CPU halt requests.
- Drives the clock block's halt, step-toggle and step-clock inputs so the CPU can free-run, single-step, burst-step N cycles, or stop.
- Sits between board buttons / control unit and the clock block; runs on the crystal clock.

Parameters:
DEBOUNCE_CYCLES, 20'd500000, consecutive stable samples required before a button level is accepted
STEP_HALF, 16'd1000, width of each high and each low phase of a generated step pulse, in i_SYS_CLOCK cycles

Ports:
i_SYS_CLOCK  in  1  system clock from on-board crystal
i_RESET  in  1  reset, asynchronous, active-high
i_BTN_RUN  in  1  raw button; press toggles between free-run and manual
i_BTN_STEP  in  1  raw button; press issues one step pulse in manual
i_BTN_BURST  in  1  raw button; press issues i_BURST_COUNT step pulses in manual
i_BURST_COUNT  in  8  burst length, sampled on burst accept; 0 = ignore press
i_CPU_HALT  in  1  halt request from control unit (HLT instruction), level
o_HALT  out  1  to clock block halt input
o_STEP_TOGGLE  out  1  one-cycle pulse to clock block step-toggle input on every mode change
o_STEP_CLOCK  out  1  to clock block step-clock input
o_MANUAL_MODE  out  1  1 while manual stepping is active (mirrors clock block mode)
o_BUSY  out  1  1 during STEP_HI/STEP_LO
o_STATE  out  3  current state encoding, for debug LEDs

Behaviour:
- Reset: state RUN; all outputs 0; counters 0; synchronisers and debouncers cleared to 0 (released). The clock block also resets to auto mode, so modes agree.
- Each button: 2-flop synchroniser, then a debounce counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples differing from it. Accepted rising edge gives a 1-cycle press strobe. Release has no action.
- i_CPU_HALT: synchronised (2 flops), rising edge detected. A held-high level does not re-trigger.
- States, with o_STATE encoding:
  - RUN (0): o_MANUAL_MODE=0, o_HALT=0, o_STEP_CLOCK=0.
  - IDLE (1): manual, waiting for a step or burst press.
  - STEP_HI (2): o_STEP_CLOCK=1.
  - STEP_LO (3): o_STEP_CLOCK=0.
  - STOPPED (4): o_HALT=1.
- Transitions:
  - RUN --run press--> IDLE; o_STEP_TOGGLE pulses in the transition cycle.
  - RUN --halt edge--> STOPPED; mode unchanged.
  - IDLE --run press--> RUN, with toggle pulse.
  - IDLE --step press--> STEP_HI, remaining=1.
  - IDLE --burst press, count≠0--> STEP_HI, remaining=count. Burst press with count 0 is ignored.
  - IDLE --halt edge--> STOPPED.
  - STEP_HI holds exactly STEP_HALF cycles, then goes to STEP_LO.
  - STEP_LO holds exactly STEP_HALF cycles, then remaining decrements. If remaining was 1, go to IDLE; else go to STEP_HI.
  - STOPPED --run press--> IDLE. If halted from RUN, o_STEP_TOGGLE pulses so mode becomes manual. o_HALT drops the same cycle.
- Abort rules:
  - Run press or halt edge during STEP_HI/STEP_LO is latched as pending.
  - A high phase is never truncated. The current STEP_LO completes, then the pending event is taken: run goes to RUN (toggle pulse), halt goes to STOPPED. Remaining steps are discarded.
  - Halt has priority over run if both are pending or both arrive in the same cycle.
- Presses not valid in the current state are dropped, not queued. Example: step press in RUN, or step/burst press while busy.
- Registered outputs: every output changes one cycle after the causing strobe. Total latency from raw button edge to output is 2 + DEBOUNCE_CYCLES + 1 cycles.
- o_BUSY = state is STEP_HI or STEP_LO.
- Asynchronous reset mid-burst returns immediately to RUN with o_STEP_CLOCK=0.

Decomposition:
- Shared package: state encoding constants (RUN/IDLE/STEP_HI/STEP_LO/STOPPED) and the default parameter values. The state encoding is shared with the debug LED decoder.
- One sub-module: debounce (synchroniser, counter and press strobe, parameterised by DEBOUNCE_CYCLES), instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, STEP_HALF=2):
- Reset, then hold i_BTN_RUN high 10 cycles -> o_STEP_TOGGLE one 1-cycle pulse; o_MANUAL_MODE=1, o_STATE=1. Bouncing the button 0/1/0 every cycle instead -> no pulse.
- In IDLE, step press -> o_STEP_CLOCK high exactly 2 cycles, low 2 cycles, then o_STATE=1; exactly one rising edge.
- In IDLE, i_BURST_COUNT=3 and burst press -> 3 step pulses, 12 cycles of o_BUSY=1; a step press mid-burst has no effect. With i_BURST_COUNT=0 -> no pulses.
- Burst of 200 in progress, run press during STEP_HI -> high phase completes 2 cycles, low completes, then o_STATE=0 with one o_STEP_TOGGLE pulse.
- In RUN, i_CPU_HALT rises and stays high -> o_HALT=1 next cycle after sync; run press -> o_HALT=0, o_MANUAL_MODE=1, no re-halt while the level stays high.
- Assert i_RESET during a burst STEP_HI -> all outputs 0 immediately; o_STATE=0 after release.

Source files
------------

// File: rtl/clock_controller_pkg.sv
// Shared definitions for the front-panel clock sequencer and the debug LED decoder.
// Holds the state encoding driven onto o_STATE and the default timing parameters.
// No logic; imported by every file of the block.
package clock_controller_pkg;

  // Encoding is visible on o_STATE, so the LED decoder depends on these values.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_STEP_HI = 3'd2,
    ST_STEP_LO = 3'd3,
    ST_STOPPED = 3'd4
  } cc_state_e;

  localparam int STATE_W = 3;
  localparam int BURST_W = 8;

  localparam logic [19:0] DEBOUNCE_CYCLES_DEF = 20'd500000;
  localparam logic [15:0] STEP_HALF_DEF       = 16'd1000;

endpackage

// File: rtl/clock_controller_if.sv
// Bundle between the board/control side and the clock sequencer.
// Latency: none, plain wires.
// Backpressure: none; buttons and halt are levels, outputs are levels or 1-cycle pulses.
// Signals: raw buttons, burst length and CPU halt level in; clock-block controls and
// debug status out.
interface clock_controller_if
  import clock_controller_pkg::*;
  ();
  logic               i_BTN_RUN;
  logic               i_BTN_STEP;
  logic               i_BTN_BURST;
  logic [BURST_W-1:0] i_BURST_COUNT;
  logic               i_CPU_HALT;
  logic               o_HALT;
  logic               o_STEP_TOGGLE;
  logic               o_STEP_CLOCK;
  logic               o_MANUAL_MODE;
  logic               o_BUSY;
  logic [STATE_W-1:0] o_STATE;

  // Board side: drives buttons and halt, observes the sequencer.
  modport master (
    output i_BTN_RUN, i_BTN_STEP, i_BTN_BURST, i_BURST_COUNT, i_CPU_HALT,
    input  o_HALT, o_STEP_TOGGLE, o_STEP_CLOCK, o_MANUAL_MODE, o_BUSY, o_STATE
  );

  // Sequencer side.
  modport slave (
    input  i_BTN_RUN, i_BTN_STEP, i_BTN_BURST, i_BURST_COUNT, i_CPU_HALT,
    output o_HALT, o_STEP_TOGGLE, o_STEP_CLOCK, o_MANUAL_MODE, o_BUSY, o_STATE
  );
endinterface

// File: rtl/clock_controller_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, 1-cycle press strobe.
// Latency: press strobe 2 + DEBOUNCE_CYCLES cycles after a clean raw rising edge.
// Backpressure: none; the strobe is fire-and-forget, releases produce nothing.
// Ports: i_SYS_CLOCK/i_RESET, btn_raw (asynchronous button), press (registered strobe).
module clock_controller_debounce
  import clock_controller_pkg::*;
#(
  // Must be at least 1.
  parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_SYS_CLOCK,
  input  logic i_RESET,
  input  logic btn_raw,
  output logic press
);

  logic        sync_1;
  logic        sync_2;
  logic        level;
  logic [19:0] stable_cnt;

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // Count consecutive samples disagreeing with the accepted level; any
      // agreeing sample restarts the run. The strobe is raised together with
      // the level update so the consumer sees it the same cycle.
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt >= DEBOUNCE_CYCLES - 20'd1) begin
        level      <= sync_2;
        stable_cnt <= '0;
        press      <= sync_2;
      end else begin
        stable_cnt <= stable_cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/clock_controller.sv
// Front-panel sequencer: run/manual toggle, single step, N-step burst, CPU halt latch.
// Latency: every output registered, one cycle after the causing strobe
//   (raw button edge to output = 2 + DEBOUNCE_CYCLES + 1 cycles).
// Backpressure: none; presses not valid in the current state are dropped.
// Ports: i_SYS_CLOCK, i_RESET (async, active-high), bus (slave modport of clock_controller_if).
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [15:0] STEP_HALF       = STEP_HALF_DEF
) (
  input logic               i_SYS_CLOCK,
  input logic               i_RESET,
  clock_controller_if.slave bus
);

  logic run_press;
  logic step_press;
  logic burst_press;

  clock_controller_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .i_SYS_CLOCK(i_SYS_CLOCK), .i_RESET(i_RESET), .btn_raw(bus.i_BTN_RUN),   .press(run_press)
  );
  clock_controller_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .i_SYS_CLOCK(i_SYS_CLOCK), .i_RESET(i_RESET), .btn_raw(bus.i_BTN_STEP),  .press(step_press)
  );
  clock_controller_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_burst (
    .i_SYS_CLOCK(i_SYS_CLOCK), .i_RESET(i_RESET), .btn_raw(bus.i_BTN_BURST), .press(burst_press)
  );

  // Halt request: synchronise, then a third flop for rising-edge detection so a
  // held level fires exactly once.
  logic halt_s1, halt_s2, halt_s3;
  logic halt_edge;

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      halt_s1 <= 1'b0;
      halt_s2 <= 1'b0;
      halt_s3 <= 1'b0;
    end else begin
      halt_s1 <= bus.i_CPU_HALT;
      halt_s2 <= halt_s1;
      halt_s3 <= halt_s2;
    end
  end

  assign halt_edge = halt_s2 & ~halt_s3;

  cc_state_e          state_q, state_nx;
  logic [15:0]        phase_q, phase_nx;
  logic [BURST_W-1:0] remain_q, remain_nx;
  logic               pend_run_q, pend_run_nx;
  logic               pend_halt_q, pend_halt_nx;
  logic               toggle_nx;

  logic halt_q, toggle_q, step_clk_q, manual_q, busy_q;

  always_comb begin
    state_nx     = state_q;
    phase_nx     = phase_q;
    remain_nx    = remain_q;
    pend_run_nx  = pend_run_q;
    pend_halt_nx = pend_halt_q;
    toggle_nx    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (halt_edge) begin
          state_nx = ST_STOPPED;
        end else if (run_press) begin
          state_nx  = ST_IDLE;
          toggle_nx = 1'b1;
        end
      end

      ST_IDLE: begin
        if (halt_edge) begin
          state_nx = ST_STOPPED;
        end else if (run_press) begin
          state_nx  = ST_RUN;
          toggle_nx = 1'b1;
        end else if (step_press) begin
          state_nx  = ST_STEP_HI;
          phase_nx  = '0;
          remain_nx = BURST_W'(1);
        end else if (burst_press && (bus.i_BURST_COUNT != '0)) begin
          state_nx  = ST_STEP_HI;
          phase_nx  = '0;
          remain_nx = bus.i_BURST_COUNT;
        end
      end

      ST_STEP_HI: begin
        // Run/halt cannot cut a high phase short; remember them for the
        // next low-phase boundary.
        pend_halt_nx = pend_halt_q | halt_edge;
        pend_run_nx  = pend_run_q | run_press;
        if (phase_q == STEP_HALF - 16'd1) begin
          state_nx = ST_STEP_LO;
          phase_nx = '0;
        end else begin
          phase_nx = phase_q + 16'd1;
        end
      end

      ST_STEP_LO: begin
        pend_halt_nx = pend_halt_q | halt_edge;
        pend_run_nx  = pend_run_q | run_press;
        if (phase_q == STEP_HALF - 16'd1) begin
          phase_nx = '0;
          if (pend_halt_nx) begin
            state_nx  = ST_STOPPED;
            remain_nx = '0;
          end else if (pend_run_nx) begin
            state_nx  = ST_RUN;
            toggle_nx = 1'b1;
            remain_nx = '0;
          end else if (remain_q == BURST_W'(1)) begin
            state_nx  = ST_IDLE;
            remain_nx = '0;
          end else begin
            state_nx  = ST_STEP_HI;
            remain_nx = remain_q - BURST_W'(1);
          end
          pend_halt_nx = 1'b0;
          pend_run_nx  = 1'b0;
        end else begin
          phase_nx = phase_q + 16'd1;
        end
      end

      ST_STOPPED: begin
        // A halt taken from RUN left the clock block in auto mode; the
        // toggle pulse brings it into manual alongside us.
        if (run_press) begin
          state_nx  = ST_IDLE;
          toggle_nx = ~manual_q;
        end
      end

      default: begin
        state_nx = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q     <= ST_RUN;
      phase_q     <= '0;
      remain_q    <= '0;
      pend_run_q  <= 1'b0;
      pend_halt_q <= 1'b0;
      halt_q      <= 1'b0;
      toggle_q    <= 1'b0;
      step_clk_q  <= 1'b0;
      manual_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_nx;
      phase_q     <= phase_nx;
      remain_q    <= remain_nx;
      pend_run_q  <= pend_run_nx;
      pend_halt_q <= pend_halt_nx;
      halt_q      <= (state_nx == ST_STOPPED);
      toggle_q    <= toggle_nx;
      step_clk_q  <= (state_nx == ST_STEP_HI);
      // Mode follows the clock block, which flips on every toggle pulse.
      manual_q    <= manual_q ^ toggle_nx;
      busy_q      <= (state_nx == ST_STEP_HI) || (state_nx == ST_STEP_LO);
    end
  end

  assign bus.o_HALT        = halt_q;
  assign bus.o_STEP_TOGGLE = toggle_q;
  assign bus.o_STEP_CLOCK  = step_clk_q;
  assign bus.o_MANUAL_MODE = manual_q;
  assign bus.o_BUSY        = busy_q;
  assign bus.o_STATE       = state_q;

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller with DEBOUNCE_CYCLES=4, STEP_HALF=2.
// A mode/time-index model predicts every output each cycle; directed scenarios
// add literal expectations on latency, pulse counts and final states.
module tb_clock_controller;
  import clock_controller_pkg::*;

  localparam int DBN  = 4;
  localparam int HALF = 2;
  localparam int PER  = 2 * HALF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  clock_controller_if bus();

  clock_controller #(
    .DEBOUNCE_CYCLES(20'(DBN)),
    .STEP_HALF(16'(HALF))
  ) dut (
    .i_SYS_CLOCK(clk),
    .i_RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw input history per edge (bit 0 = value sampled at the current edge).
  logic [7:0] h_run = '0, h_step = '0, h_burst = '0;
  logic [3:0] h_halt = '0;
  logic lv_run = 0, lv_step = 0, lv_burst = 0;
  logic acc_run = 0, acc_step = 0, acc_burst = 0;
  int m_manual = 0, m_stopped = 0, m_busy = 0, m_toggle = 0;
  int m_t = 0, m_n = 0, pend_h = 0, pend_r = 0;

  // A level is accepted when the DBN synchronised samples (raw delayed by 2)
  // all differ from it.
  task automatic deb(input logic [7:0] h, inout logic lv, output logic rise);
    rise = 1'b0;
    if (h[5:2] == {4{~lv}}) begin
      rise = ~lv;
      lv   = ~lv;
    end
  endtask

  task automatic model_reset();
    h_run = '0; h_step = '0; h_burst = '0; h_halt = '0;
    lv_run = 0; lv_step = 0; lv_burst = 0;
    acc_run = 0; acc_step = 0; acc_burst = 0;
    m_manual = 0; m_stopped = 0; m_busy = 0; m_toggle = 0;
    m_t = 0; m_n = 0; pend_h = 0; pend_r = 0;
  endtask

  task automatic model_step();
    logic ev_run, ev_step, ev_burst, ev_halt;
    h_run   = {h_run[6:0],   bus.i_BTN_RUN};
    h_step  = {h_step[6:0],  bus.i_BTN_STEP};
    h_burst = {h_burst[6:0], bus.i_BTN_BURST};
    h_halt  = {h_halt[2:0],  bus.i_CPU_HALT};
    // Presses accepted on the previous edge act on this one.
    ev_run   = acc_run;
    ev_step  = acc_step;
    ev_burst = acc_burst;
    ev_halt  = h_halt[2] & ~h_halt[3];
    deb(h_run, lv_run, acc_run);
    deb(h_step, lv_step, acc_step);
    deb(h_burst, lv_burst, acc_burst);

    m_toggle = 0;
    if (m_busy != 0) begin
      if (ev_halt) pend_h = 1;
      if (ev_run)  pend_r = 1;
      m_t++;
      if (m_t % PER == 0) begin
        if (pend_h != 0) begin
          m_busy = 0; m_stopped = 1;
        end else if (pend_r != 0) begin
          m_busy = 0; m_manual = 0; m_toggle = 1;
        end else if (m_t == PER * m_n) begin
          m_busy = 0;
        end
        if (m_busy == 0) begin
          pend_h = 0; pend_r = 0;
        end
      end
    end else if (m_stopped != 0) begin
      if (ev_run) begin
        m_stopped = 0;
        if (m_manual == 0) m_toggle = 1;
        m_manual = 1;
      end
    end else if (m_manual == 0) begin
      if (ev_halt) m_stopped = 1;
      else if (ev_run) begin m_manual = 1; m_toggle = 1; end
    end else begin
      if (ev_halt) m_stopped = 1;
      else if (ev_run) begin m_manual = 0; m_toggle = 1; end
      else if (ev_step) begin m_busy = 1; m_t = 0; m_n = 1; end
      else if (ev_burst && bus.i_BURST_COUNT != 8'd0) begin
        m_busy = 1; m_t = 0; m_n = int'(bus.i_BURST_COUNT);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step();
  end

  function automatic int exp_state();
    if (m_stopped != 0) return 4;
    if (m_busy != 0)    return ((m_t % PER) < HALF) ? 2 : 3;
    return (m_manual != 0) ? 1 : 0;
  endfunction

  // ---------------- per-cycle compare and event counters ----------------
  int n_tog = 0, n_hi = 0, n_rise = 0, n_busy = 0;
  logic prev_sc = 1'b0;

  initial forever begin
    @(negedge clk);
    check("halt",   int'(bus.o_HALT),        m_stopped);
    check("toggle", int'(bus.o_STEP_TOGGLE), m_toggle);
    check("stepclk", int'(bus.o_STEP_CLOCK),
          ((m_busy != 0) && ((m_t % PER) < HALF)) ? 1 : 0);
    check("manual", int'(bus.o_MANUAL_MODE), m_manual);
    check("busy",   int'(bus.o_BUSY),        m_busy);
    check("state",  int'(bus.o_STATE),       exp_state());
    n_tog  += int'(bus.o_STEP_TOGGLE);
    n_hi   += int'(bus.o_STEP_CLOCK);
    n_busy += int'(bus.o_BUSY);
    if (bus.o_STEP_CLOCK && !prev_sc) n_rise++;
    prev_sc = bus.o_STEP_CLOCK;
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after a falling edge, well clear of the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.i_BTN_RUN = v;
      1: bus.i_BTN_STEP = v;
      2: bus.i_BTN_BURST = v;
      default: ;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(8);
    set_btn(b, 1'b0);
    cyc(10);
  endtask

  task automatic clr();
    n_tog = 0; n_hi = 0; n_rise = 0; n_busy = 0;
  endtask

  initial begin
    int found;
    bus.i_BTN_RUN = 1'b0;
    bus.i_BTN_STEP = 1'b0;
    bus.i_BTN_BURST = 1'b0;
    bus.i_BURST_COUNT = 8'd0;
    bus.i_CPU_HALT = 1'b0;
    #1 rst = 1'b1;
    cyc(3);
    check("reset_state", int'(bus.o_STATE), 0);
    check("reset_outs", int'({bus.o_HALT, bus.o_STEP_TOGGLE, bus.o_STEP_CLOCK,
                              bus.o_MANUAL_MODE, bus.o_BUSY}), 0);
    rst = 1'b0;
    cyc(2);

    // Bouncing run button never settles: no mode change.
    clr();
    for (int i = 0; i < 20; i++) begin
      set_btn(0, i[0]);
      cyc(1);
    end
    set_btn(0, 1'b0);
    cyc(10);
    check("bounce_toggles", n_tog, 0);
    check("bounce_state", int'(bus.o_STATE), 0);

    // Clean run press: toggle exactly 2+4+1 cycles after the raw edge.
    clr();
    set_btn(0, 1'b1);
    cyc(6);
    check("run_lat_early", int'(bus.o_STEP_TOGGLE), 0);
    cyc(1);
    check("run_lat_pulse", int'(bus.o_STEP_TOGGLE), 1);
    cyc(3);
    set_btn(0, 1'b0);
    cyc(10);
    check("run_toggles", n_tog, 1);
    check("run_state", int'(bus.o_STATE), 1);
    check("run_manual", int'(bus.o_MANUAL_MODE), 1);

    // Single step.
    clr();
    press(1);
    check("step_hi_cycles", n_hi, 2);
    check("step_rises", n_rise, 1);
    check("step_busy", n_busy, 4);
    check("step_state", int'(bus.o_STATE), 1);

    // Burst of 3 with a step press landing mid-burst.
    bus.i_BURST_COUNT = 8'd3;
    clr();
    set_btn(2, 1'b1);
    cyc(8);
    set_btn(2, 1'b0);
    set_btn(1, 1'b1);
    cyc(6);
    set_btn(1, 1'b0);
    cyc(20);
    check("burst3_busy", n_busy, 12);
    check("burst3_rises", n_rise, 3);
    check("burst3_state", int'(bus.o_STATE), 1);

    // Burst length 0 is ignored.
    bus.i_BURST_COUNT = 8'd0;
    clr();
    press(2);
    check("burst0_rises", n_rise, 0);
    check("burst0_busy", n_busy, 0);
    check("burst0_state", int'(bus.o_STATE), 1);

    // Burst of 200 aborted by run press arriving in a high phase.
    bus.i_BURST_COUNT = 8'd200;
    clr();
    set_btn(2, 1'b1);
    cyc(8);
    set_btn(2, 1'b0);
    cyc(2);
    set_btn(0, 1'b1);
    cyc(8);
    set_btn(0, 1'b0);
    cyc(15);
    check("abort_busy", n_busy, 12);
    check("abort_hi", n_hi, 6);
    check("abort_rises", n_rise, 3);
    check("abort_toggles", n_tog, 1);
    check("abort_state", int'(bus.o_STATE), 0);
    check("abort_manual", int'(bus.o_MANUAL_MODE), 0);

    // CPU halt from RUN, held high; run press resumes into manual.
    clr();
    bus.i_CPU_HALT = 1'b1;
    cyc(2);
    check("halt_early", int'(bus.o_HALT), 0);
    cyc(1);
    check("halt_set", int'(bus.o_HALT), 1);
    check("halt_state", int'(bus.o_STATE), 4);
    check("halt_manual", int'(bus.o_MANUAL_MODE), 0);
    cyc(3);
    press(0);
    check("resume_halt", int'(bus.o_HALT), 0);
    check("resume_manual", int'(bus.o_MANUAL_MODE), 1);
    check("resume_toggles", n_tog, 1);
    cyc(10);
    check("no_rehalt_state", int'(bus.o_STATE), 1);
    bus.i_CPU_HALT = 1'b0;
    cyc(5);

    // Reset during a burst high phase.
    bus.i_BURST_COUNT = 8'd200;
    set_btn(2, 1'b1);
    cyc(8);
    set_btn(2, 1'b0);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (bus.o_STATE == 3'd2) found = 1;
      else cyc(1);
    end
    check("midburst_reached", found, 1);
    rst = 1'b1;
    #1;
    check("arst_stepclk", int'(bus.o_STEP_CLOCK), 0);
    check("arst_state", int'(bus.o_STATE), 0);
    check("arst_outs", int'({bus.o_HALT, bus.o_STEP_TOGGLE, bus.o_STEP_CLOCK,
                             bus.o_MANUAL_MODE, bus.o_BUSY}), 0);
    cyc(1);
    rst = 1'b0;
    cyc(5);
    check("post_rst_state", int'(bus.o_STATE), 0);
    check("post_rst_manual", int'(bus.o_MANUAL_MODE), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
